// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus parallel byte outputs of the 8N1 receiver.
// slave  = the receiver itself, master = board/consumer side.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;

  modport slave  (input rx, output rx_data, rx_ready, rx_busy, frame_err);
  modport master (output rx, input rx_data, rx_ready, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first), mid-bit sampling, one-clk
// rx_ready / frame_err strobes.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around each sample
// point (target-1, target, target+1), decision taken one clock later.
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  // Room for target+1 in the voting build.
  localparam int CW = $clog2(BIT_CYC + 2);
  typedef logic [CW-1:0] cnt_t;

  // Decision points; reloading with OFS keeps later sample points on the
  // same mid-bit grid even though the vote decides one clock late.
  localparam cnt_t START_HIT = cnt_t'(HALF_CYC - 1 + OFS);
  localparam cnt_t BIT_HIT   = cnt_t'(BIT_CYC - 1 + OFS);
  localparam cnt_t RELOAD    = cnt_t'(OFS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic       rx_m, rx_s;
  logic [1:0] hist;   // rx_s one and two clocks ago
  logic [1:0] fill;   // synchronizer holds real line samples once fill[1]=1
  logic       armed;  // line seen high after reset; edges are trusted
  logic       fall, samp;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  // Input synchronizer, sample history and post-reset arming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      hist  <= 2'b11;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_m  <= bus.rx;
      rx_s  <= rx_m;
      hist  <= {hist[0], rx_s};
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & rx_s);
    end
  end

  // The preset-1 synchronizer would fake a falling edge if the line is low at
  // reset release; arming on a real high sample suppresses that.
  assign fall = armed & hist[0] & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
  assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign samp = rx_s;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, bit timing and output strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == START_HIT) begin
          cnt_d = RELOAD;
          if (samp) begin
            state_d = IDLE;
          end else begin
            busy_d  = 1'b1;
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_HIT) begin
          cnt_d       = RELOAD;
          sh_d[idx_q] = samp;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_HIT) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (samp) begin
            data_d  = sh_q;
            ready_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_ready  = ready_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames through a scoreboard; a monitor pops the
// expected event on every rx_ready / frame_err strobe. Bit rate is scaled up
// (16 clocks per bit) to keep the run short.
module tb_uart_rx;
  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 3125000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int EXP_LAT  = BIT * 9 + BIT / 2 + 3;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Serialize one frame; a bad stop bit is followed by one idle-high bit so
  // the next start edge is real.
  task automatic send(input logic [7:0] d, input bit stop_ok);
    exp_t e;
    @(posedge clk); #2;
    e.is_err = !stop_ok; e.data = d; e.t0 = cyc;
    sb.push_back(e);
    bus.rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_cyc(BIT);
    end
    bus.rx = stop_ok;
    wait_cyc(BIT);
    bus.rx = 1'b1;
    if (!stop_ok) wait_cyc(BIT);
  endtask

  // Start a frame and pull reset in the middle of data bit ab.
  task automatic send_abort(input logic [7:0] d, input int ab);
    @(posedge clk); #2;
    bus.rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < ab; i++) begin
      bus.rx = d[i];
      wait_cyc(BIT);
    end
    bus.rx = d[ab];
    wait_cyc(BIT / 2);
    chk("busy_before_abort", bus.rx_busy == 1'b1, bus.rx_busy, 1);
    rst = 1'b0;
    #1;
    chk("busy_after_abort", bus.rx_busy == 1'b0, bus.rx_busy, 0);
    chk("ready_after_abort", bus.rx_ready == 1'b0, bus.rx_ready, 0);
    bus.rx = 1'b1;
    wait_cyc(4);
    rst = 1'b1;
  endtask

  // Monitor: exclusivity, data hold between strobes, and scoreboard pops.
  initial begin
    logic [7:0] last;
    exp_t e;
    int lat;
    last = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last = 8'h00;
      end else begin
        if (bus.rx_ready && bus.frame_err)
          chk("ready_err_exclusive", 1'b0, 1, 0);
        if (bus.rx_ready || bus.frame_err) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", 1'b0, {bus.rx_ready, bus.frame_err}, 0);
          end else begin
            e = sb.pop_front();
            chk("event_kind", bus.frame_err == e.is_err && bus.rx_ready == !e.is_err,
                {bus.rx_ready, bus.frame_err}, {!e.is_err, e.is_err});
            lat = cyc - e.t0;
            chk("latency", lat >= EXP_LAT - BIT && lat <= EXP_LAT + BIT, lat, EXP_LAT);
            if (e.is_err)
              chk("data_kept_on_err", bus.rx_data == last, bus.rx_data, last);
            else begin
              chk("rx_data", bus.rx_data == e.data, bus.rx_data, e.data);
              last = e.data;
            end
          end
        end else begin
          chk("rx_data_hold", bus.rx_data == last, bus.rx_data, last);
        end
      end
    end
  end

  initial begin
    bit seen;
    bus.rx = 1'b1;
    #5 rst = 1'b0;
    #100;
    chk("rst_data", bus.rx_data == 8'h00, bus.rx_data, 0);
    chk("rst_ready", bus.rx_ready == 1'b0, bus.rx_ready, 0);
    chk("rst_busy", bus.rx_busy == 1'b0, bus.rx_busy, 0);
    chk("rst_ferr", bus.frame_err == 1'b0, bus.frame_err, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    wait_cyc(5);
    chk("idle_busy", bus.rx_busy == 1'b0, bus.rx_busy, 0);
    chk("idle_data", bus.rx_data == 8'h00, bus.rx_data, 0);

    send(8'hA5, 1'b1);
    wait_cyc(3 * BIT);
    send(8'h5A, 1'b1);
    wait_cyc(BIT);

    // Short low glitch, well under half a bit.
    bus.rx = 1'b0;
    wait_cyc(3);
    bus.rx = 1'b1;
    seen = 1'b0;
    repeat (2 * BIT) begin
      @(negedge clk);
      seen |= bus.rx_busy;
    end
    chk("glitch_busy", seen == 1'b0, seen, 0);
    send(8'h3C, 1'b1);
    wait_cyc(BIT);

    send(8'hFF, 1'b0);
    send(8'h81, 1'b1);
    wait_cyc(2 * BIT);

    send_abort(8'hC3, 4);
    wait_cyc(BIT);
    send(8'h96, 1'b1);
    wait_cyc(BIT);

    // Line held low across reset release must not start a frame.
    rst = 1'b0;
    bus.rx = 1'b0;
    wait_cyc(5);
    rst = 1'b1;
    seen = 1'b0;
    repeat (3 * BIT) begin
      @(negedge clk);
      seen |= bus.rx_busy;
    end
    chk("held_low_busy", seen == 1'b0, seen, 0);
    @(posedge clk); #2;
    bus.rx = 1'b1;
    wait_cyc(BIT);
    send(8'h6E, 1'b1);

    // Random traffic, mostly back-to-back, some framing errors.
    for (int n = 0; n < 24; n++) begin
      send(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0);
      wait_cyc($urandom_range(0, 3));
    end

    for (int i = 0; i < 40 * BIT && sb.size() != 0; i++) @(posedge clk);
    wait_cyc(2 * BIT);
    chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
